// File: rtl/axi_hs_master.sv
// Burst initiator and in-order result checker for the valid/ready operand-pair adder stage.
// Drives len (a,b) pairs, predicts each sum into a small FIFO and compares returned sums.
module axi_hs_master #(
   parameter int DW         = 8,
   parameter int CNT_W      = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int TO_CYC     = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic [DW-1:0]    seed_a,
   input  logic [DW-1:0]    seed_b,
   input  logic [DW-1:0]    step,
   input  logic [7:0]       bp_mask,
   output logic [DW-1:0]    tx_a,
   output logic [DW-1:0]    tx_b,
   output logic             tx_valid,
   input  logic             tx_ready,
   input  logic [DW-1:0]    rx_data,
   input  logic             rx_valid,
   output logic             rx_ready,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] tx_cnt,
   output logic [CNT_W-1:0] rx_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [1:0]       dbg_state
);
   // Handshake: a transfer happens at a rising clk edge where valid && ready; once valid
   // is high, its payload and valid itself hold stable until that edge.

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TO_CYC + 1);
   localparam logic [AW:0]   FULL    = (AW+1)'(FIFO_DEPTH);
   localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

   state_t           state_q, state_d;
   logic [DW-1:0]    tx_a_q, tx_a_d, tx_b_q, tx_b_d, step_q, step_d;
   logic             tx_valid_q, tx_valid_d, timeout_q, timeout_d, done_q, done_d;
   logic [CNT_W-1:0] len_q, len_d, tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [2:0]       bp_idx_q, bp_idx_d;
   logic [TW-1:0]    to_cnt_q, to_cnt_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      occ_q, occ_d;
   logic [DW-1:0]    fifo_mem [FIFO_DEPTH];

   logic             busy_w, rx_ready_w, tx_hs, rx_hs, push, pop, rx_err, to_fire;
   logic [AW:0]      err_inc;
   logic [CNT_W:0]   err_sum;
   logic [CNT_W-1:0] err_sat;

   assign busy_w     = (state_q == SEND) || (state_q == DRAIN);
   assign rx_ready_w = busy_w && bp_mask[bp_idx_q];
   assign tx_hs      = tx_valid_q && tx_ready;
   assign rx_hs      = rx_valid && rx_ready_w;
   assign push       = tx_hs;
   assign pop        = rx_hs && (occ_q != '0);
   assign rx_err     = rx_hs && ((occ_q == '0) || (rx_data != fifo_mem[rd_ptr_q]));
   assign to_fire    = (state_q == DRAIN) && (rx_cnt_q != len_q) && !rx_hs && (to_cnt_q == TO_LAST);

   // On timeout, every prediction still in the FIFO is charged as an error.
   assign err_inc = to_fire ? occ_q : {{AW{1'b0}}, rx_err};
   assign err_sum = {1'b0, err_cnt_q} + (CNT_W+1)'(err_inc);
   assign err_sat = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];

   always_comb begin
      state_d    = state_q;
      tx_a_d     = tx_a_q;
      tx_b_d     = tx_b_q;
      step_d     = step_q;
      len_d      = len_q;
      tx_valid_d = tx_valid_q;
      timeout_d  = timeout_q;
      done_d     = 1'b0;
      to_cnt_d   = to_cnt_q;
      bp_idx_d   = busy_w ? bp_idx_q + 3'd1 : bp_idx_q;
      wr_ptr_d   = wr_ptr_q + AW'(push);
      rd_ptr_d   = rd_ptr_q + AW'(pop);
      occ_d      = occ_q + (AW+1)'(push) - (AW+1)'(pop);
      tx_cnt_d   = tx_cnt_q;
      rx_cnt_d   = rx_cnt_q + CNT_W'(pop);
      err_cnt_d  = err_sat;
      case (state_q)
         IDLE: begin
            if (start) begin
               tx_a_d     = seed_a;
               tx_b_d     = seed_b;
               step_d     = step;
               len_d      = len;
               tx_cnt_d   = '0;
               rx_cnt_d   = '0;
               err_cnt_d  = '0;
               timeout_d  = 1'b0;
               to_cnt_d   = '0;
               bp_idx_d   = '0;
               wr_ptr_d   = '0;
               rd_ptr_d   = '0;
               occ_d      = '0;
               tx_valid_d = (len != '0);
               state_d    = (len != '0) ? SEND : DONE;
            end
         end
         SEND: begin
            if (tx_hs) begin
               tx_cnt_d = tx_cnt_q + CNT_W'(1);
               tx_a_d   = tx_a_q + step_q;
               tx_b_d   = tx_b_q - DW'(1);
               if (tx_cnt_q + CNT_W'(1) == len_q) begin
                  tx_valid_d = 1'b0;
                  state_d    = DRAIN;
               end else begin
                  tx_valid_d = (occ_d != FULL);
               end
            end else if (!tx_valid_q) begin
               // Throttled: the next beat is already loaded, raise valid once space frees.
               tx_valid_d = (occ_d != FULL);
            end
         end
         DRAIN: begin
            if (rx_cnt_q == len_q) begin
               state_d = DONE;
            end else if (rx_hs) begin
               to_cnt_d = '0;
            end else if (to_fire) begin
               timeout_d = 1'b1;
               state_d   = DONE;
            end else begin
               to_cnt_d = to_cnt_q + TW'(1);
            end
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         tx_a_q     <= '0;
         tx_b_q     <= '0;
         step_q     <= '0;
         len_q      <= '0;
         tx_valid_q <= 1'b0;
         timeout_q  <= 1'b0;
         done_q     <= 1'b0;
         to_cnt_q   <= '0;
         bp_idx_q   <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         tx_cnt_q   <= '0;
         rx_cnt_q   <= '0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         tx_a_q     <= tx_a_d;
         tx_b_q     <= tx_b_d;
         step_q     <= step_d;
         len_q      <= len_d;
         tx_valid_q <= tx_valid_d;
         timeout_q  <= timeout_d;
         done_q     <= done_d;
         to_cnt_q   <= to_cnt_d;
         bp_idx_q   <= bp_idx_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         tx_cnt_q   <= tx_cnt_d;
         rx_cnt_q   <= rx_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= tx_a_q + tx_b_q;
   end

   assign tx_a      = tx_a_q;
   assign tx_b      = tx_b_q;
   assign tx_valid  = tx_valid_q;
   assign rx_ready  = rx_ready_w;
   assign busy      = busy_w;
   assign done      = done_q;
   assign timeout   = timeout_q;
   assign tx_cnt    = tx_cnt_q;
   assign rx_cnt    = rx_cnt_q;
   assign err_cnt   = err_cnt_q;
   assign dbg_state = state_q;

endmodule

// File: doc/axi_hs_master.md
Name: axi_hs_master

Overview:
- Initiator and result sink for the team's valid/ready operand-pair adder stage.
- On a start pulse it drives `len` operand pairs (a, b) onto the stage's input channel, obeying valid/ready hold rules.
- It consumes the stage's sum channel using a programmable backpressure pattern, checks each sum in order against an internally predicted value, and reports counts, errors and completion.
- Used as the stimulus and check end of the stage in subsystem-level loops.

Parameters:
DW, 8, operand and result width
CNT_W, 8, width of len and of all counters
FIFO_DEPTH, 4, expected-value FIFO entries (power of 2, >=2); this is the in-flight limit
TO_CYC, 255, DRAIN timeout in consecutive cycles with no result handshake

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a burst; accepted only in IDLE
len  in  CNT_W  beats in the burst; sampled when start is accepted
seed_a  in  DW  first a operand; sampled when start is accepted
seed_b  in  DW  first b operand; sampled when start is accepted
step  in  DW  increment applied to a per beat; sampled when start is accepted
bp_mask  in  8  rx_ready pattern; live input, not sampled
tx_a  out  DW  operand a
tx_b  out  DW  operand b
tx_valid  out  1  operand pair valid
tx_ready  in  1  downstream ready for the operand pair
rx_data  in  DW  returned sum
rx_valid  in  1  sum valid
rx_ready  out  1  ready to accept a sum
busy  out  1  high in SEND and DRAIN
done  out  1  one-cycle completion pulse
timeout  out  1  sticky; set on DRAIN timeout, cleared on next accepted start
tx_cnt  out  CNT_W  operand handshakes this burst
rx_cnt  out  CNT_W  matched-or-mismatched results popped this burst
err_cnt  out  CNT_W  saturating error count

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: every output is 0; FSM is in IDLE; FIFO is empty; bp_idx is 0. A reset mid-burst abandons the burst immediately, with no done pulse.
- FSM states: IDLE, SEND, DRAIN, DONE.
- IDLE:
  - On start with len != 0, go to SEND.
  - On start with len == 0, go to DONE.
  - Accepting start clears tx_cnt, rx_cnt, err_cnt, timeout, bp_idx and the FIFO.
  - start is ignored in every other state.
- Beat generation: beat i has a_i = seed_a + i*step and b_i = seed_b - i, both mod 2^DW.
- Expected value: exp_i = (a_i + b_i) mod 2^DW, carry discarded.
- SEND timing:
  - tx_valid is registered and rises the cycle after start is accepted, presenting beat 0.
  - Handshake = tx_valid && tx_ready at a clock edge. On a handshake: push exp_i, increment tx_cnt, and present beat i+1 in the next cycle. Throughput is 1 beat/cycle.
- SEND hold and flow rules:
  - Once tx_valid is high, tx_a/tx_b/tx_valid hold stable until the handshake.
  - tx_valid never rises while the FIFO is full. An asserted tx_valid is never withdrawn.
  - A same-cycle push and pop leaves the FIFO occupancy unchanged.
  - After the handshake of beat len-1, tx_valid is 0 the next cycle and the FSM goes to DRAIN.
- Result side:
  - rx_ready = bp_mask[bp_idx] in SEND and DRAIN; 0 in IDLE and DONE.
  - bp_idx is 3 bits and increments every busy cycle, wrapping 7 to 0.
  - On an rx handshake with the FIFO non-empty: pop, increment rx_cnt, and increment err_cnt if rx_data != head.
  - On an rx handshake with the FIFO empty: increment err_cnt only.
  - err_cnt saturates at all-ones.
- DRAIN:
  - When rx_cnt == len, go to DONE.
  - A counter counts consecutive cycles without an rx handshake and resets on each handshake.
  - When the counter reaches TO_CYC: set timeout, add the remaining FIFO occupancy to err_cnt (saturating), and go to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE. Counters keep their values until the next accepted start.

Test Plan:
1. Basic burst:
   - Stimulus: len=4, seed_a=1, seed_b=2, step=1, tx_ready=1, bp_mask=FF, ideal 1-cycle adder in loop.
   - Response: tx pairs (1,2),(2,1),(3,0),(4,FF); all sums 3; tx_cnt=rx_cnt=4; err_cnt=0; one done pulse; timeout=0.
2. Input backpressure:
   - Stimulus: same burst, tx_ready toggling 1010...
   - Response: tx_a/tx_b/tx_valid unchanged across every ready-low cycle; 4 handshakes; err_cnt=0.
3. FIFO-full throttle:
   - Stimulus: len=8, bp_mask=00; after 20 cycles set bp_mask=FF.
   - Response: exactly 4 tx handshakes, then tx_valid held 0; burst then completes with rx_cnt=8, err_cnt=0.
4. Mismatch detection:
   - Stimulus: loop adder corrupts beat 2 (returns 0x55).
   - Response: err_cnt=1, rx_cnt=4, done pulses.
5. Degenerate and stall cases:
   - len=0 -> done pulses in the 2nd cycle after start, tx_valid never rises.
   - Adder drops the last result -> after TO_CYC idle cycles, timeout=1, err_cnt=1, done pulses.
6. Reset mid-burst:
   - Stimulus: assert rst_n=0 during SEND with tx_valid high.
   - Response: all outputs 0 asynchronously; no done pulse; a new start runs a clean burst.
